// File: rtl/div_pkg.sv
// Shared constants, FSM state type and sign helper for the multi-cycle divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 34;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's complement magnitude when signed; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                  input logic              en);
    return (en && v[DIV_WIDTH-1]) ? (DIV_WIDTH'(0) - v) : v;
  endfunction

endpackage

// File: rtl/divider_32bit_if.sv
// Request/response bundle between the execute stage and the divider.
interface divider_32bit_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);

  logic             Start;
  logic             Signed;
  logic             Flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Lo;
  logic [WIDTH-1:0] Hi;
  logic             DivByZero;

  modport master (
    output Start, Signed, Flush, A, B,
    input  Busy, Done, Lo, Hi, DivByZero
  );

  modport slave (
    input  Start, Signed, Flush, A, B,
    output Busy, Done, Lo, Hi, DivByZero
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Partial remainder stays below the divisor, so the top bit of w_diff is a clean borrow flag.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_dsr};
  assign o_qbit  = ~w_diff[WIDTH+1];
  assign o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for div/divu: fixed 34-cycle latency, quotient on Lo, remainder on Hi.
//
// state | meaning
// IDLE  | waiting for Start; results held
// RUN   | 32 shift-subtract iterations, one quotient bit per cycle
// FIX   | sign correction / divide-by-zero override, results registered
// DONE  | Done pulse for one cycle
module divider_32bit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           Clk,
  input  logic           Reset_n,
  divider_32bit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_a;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem;
  logic             w_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dsr   <= '0;
      r_a     <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_dbz   <= 1'b0;
    end else if (bus.Flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_dvd   <= abs_val(bus.A, bus.Signed);
            r_dsr   <= abs_val(bus.B, bus.Signed);
            r_a     <= bus.A;
            r_qneg  <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_rneg  <= bus.Signed & bus.A[WIDTH-1];
            r_rem   <= '0;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_state <= RUN;
          end
        end
        RUN: begin
          // Quotient bits fill the dividend register from the bottom as dividend bits leave the top.
          r_rem <= w_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (r_dsr == '0) begin
            r_lo  <= WIDTH'(DIV_ZERO_QUOT);
            r_hi  <= r_a;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= r_qneg ? (WIDTH'(0) - r_dvd) : r_dvd;
            r_hi  <= r_rneg ? (WIDTH'(0) - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
            r_dbz <= 1'b0;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy      = (r_state != IDLE);
  assign bus.Done      = (r_state == DONE);
  assign bus.Lo        = r_lo;
  assign bus.Hi        = r_hi;
  assign bus.DivByZero = r_dbz;

endmodule

// File: tb/tb_divider_32bit.sv
// Directed bench for divider_32bit: latency, signed/unsigned results, corners, Start/Flush/Reset control.
module tb_divider_32bit;
  import div_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  divider_32bit_if #(.WIDTH(32)) bus ();

  divider_32bit #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally pulse a stray Start with junk operands at cycle ign_cyc.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int ign_cyc, output int done_cyc, output int busy_cnt);
    @(negedge Clk);
    bus.A      = a;
    bus.B      = b;
    bus.Signed = s;
    bus.Start  = 1'b1;
    @(posedge Clk);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      bus.Start = (c == ign_cyc);
      if (c == ign_cyc) begin
        bus.A      = 32'h0000_DEAD;
        bus.B      = 32'h0000_0003;
        bus.Signed = ~s;
      end
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cyc = c;
        break;
      end
    end
    bus.Start = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int ign_cyc, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dz);
    int done_cyc;
    int busy_cnt;
    run_op(a, b, s, ign_cyc, done_cyc, busy_cnt);
    chk({tag, "_latency"}, done_cyc, DIV_LATENCY);
    chk({tag, "_lo"}, bus.Lo, exp_lo);
    chk({tag, "_hi"}, bus.Hi, exp_hi);
    chk({tag, "_dbz"}, {31'b0, bus.DivByZero}, {31'b0, exp_dz});
    @(negedge Clk);
    chk({tag, "_done_pulse"}, {31'b0, bus.Done}, 32'd0);
    chk({tag, "_lo_hold"}, bus.Lo, exp_lo);
  endtask

  initial begin
    int done_cyc;
    int busy_cnt;
    int done_seen;

    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.Flush  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    Reset_n    = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_done", {31'b0, bus.Done}, 32'd0);
    chk("rst_dbz", {31'b0, bus.DivByZero}, 32'd0);
    chk("rst_lo", bus.Lo, 32'h0);
    chk("rst_hi", bus.Hi, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // 100 / 7 unsigned, with busy width checked explicitly
    run_op(32'd100, 32'd7, 1'b0, 0, done_cyc, busy_cnt);
    chk("divu_latency", done_cyc, 34);
    chk("divu_busy_cycles", busy_cnt, 34);
    chk("divu_lo", bus.Lo, 32'd14);
    chk("divu_hi", bus.Hi, 32'd2);
    chk("divu_dbz", {31'b0, bus.DivByZero}, 32'd0);
    @(negedge Clk);
    chk("divu_busy_after", {31'b0, bus.Busy}, 32'd0);
    chk("divu_done_after", {31'b0, bus.Done}, 32'd0);
    chk("divu_lo_hold", bus.Lo, 32'd14);

    op_check("div_neg_a", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    op_check("div_neg_b", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1, 1'b0);
    op_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'h0, 1'b0);
    op_check("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    op_check("divu_big", 32'h8000_0000, 32'd3, 1'b0, 0, 32'h2AAA_AAAA, 32'd2, 1'b0);
    op_check("div_zero", 32'hFFFF_FFFB, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Reset in the middle of RUN wipes everything, including the held div-by-zero result
    @(negedge Clk);
    bus.A = 32'hFFFF_FFFF; bus.B = 32'd3; bus.Signed = 1'b0; bus.Start = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.Done}, 32'd0);
    chk("midrst_dbz", {31'b0, bus.DivByZero}, 32'd0);
    chk("midrst_lo", bus.Lo, 32'h0);
    chk("midrst_hi", bus.Hi, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    op_check("post_rst", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0);

    op_check("start_ignored", 32'd1000, 32'd10, 1'b0, 10, 32'd100, 32'd0, 1'b0);

    // Flush at cycle 20 aborts; prior results stay
    @(negedge Clk);
    bus.A = 32'd50; bus.B = 32'd3; bus.Signed = 1'b0; bus.Start = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    chk("flush_busy_before", {31'b0, bus.Busy}, 32'd1);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    chk("flush_busy_after", {31'b0, bus.Busy}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (bus.Done) done_seen++;
    end
    chk("flush_no_done", done_seen, 0);
    chk("flush_lo_kept", bus.Lo, 32'd100);
    chk("flush_hi_kept", bus.Hi, 32'd0);

    // Flush together with Start in IDLE drops the request
    @(negedge Clk);
    bus.A = 32'd9; bus.B = 32'd2; bus.Start = 1'b1; bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    chk("flush_start_busy", {31'b0, bus.Busy}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (bus.Done) done_seen++;
    end
    chk("flush_start_no_done", done_seen, 0);
    chk("flush_start_lo_kept", bus.Lo, 32'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_32bit.md
# divider_32bit

Multi-cycle 32-bit integer divider for the MIPS execute stage: the inverse of the single-cycle combinational multiplier, serving `div`/`divu`. It accepts a dividend/divisor pair on a start strobe, runs a restoring shift-subtract loop one quotient bit per cycle, and returns the quotient (LO) and remainder (HI) with a done pulse. Latency is fixed, so the hazard unit stalls on `Busy` alone.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width.
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle request; sampled only in IDLE.
- `Signed`  in  1  1 = `div` (two's complement), 0 = `divu`; captured with `Start`.
- `Flush`  in  1  pipeline flush; aborts any operation in progress.
- `A`  in  WIDTH  dividend; captured with `Start`.
- `B`  in  WIDTH  divisor; captured with `Start`.
- `Busy`  out  1  high from the cycle after `Start` is accepted until `Done`.
- `Done`  out  1  one-cycle pulse when `Lo`/`Hi` are valid.
- `Lo`  out  WIDTH  quotient; held until the next accepted `Start`.
- `Hi`  out  WIDTH  remainder; held until the next accepted `Start`.
- `DivByZero`  out  1  set with `Done` when `B` was 0; held with `Lo`/`Hi`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE:** on `Start`, latch the operands.
  - Magnitudes: `|A|` and `|B|` when `Signed`, else raw. The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Latch sign flags: `qneg = Signed & (A[31]^B[31])` and `rneg = Signed & A[31]`.
  - Clear the 33-bit partial remainder, load the counter with 31, go to RUN.
- **RUN:** each cycle, shift the next dividend bit (MSB first) into the partial remainder and trial-subtract the divisor magnitude.
  - Non-negative result: keep the difference, shift in quotient bit 1.
  - Negative result: restore, shift in quotient bit 0.
  - Leave for FIX after the iteration with counter = 0, i.e. 32 iterations.
- **FIX:**
  - Quotient is negated if `qneg`; remainder is negated if `rneg`.
  - Register results into `Lo`/`Hi`; go to DONE.
- **DONE:** assert `Done` for one cycle, return to IDLE.
- **Divide by zero:**
  - Loop runs unchanged, so latency stays constant.
  - FIX forces `Lo` = 0xFFFFFFFF and `Hi` = original `A`, and sets `DivByZero`.
  - Sign correction is not applied in this case.
- **Overflow** (`Signed`, A = 0x80000000, B = 0xFFFFFFFF): result is `Lo` = 0x80000000, `Hi` = 0. This falls out of the magnitude arithmetic with no special case.
- **Start while busy:** `Start` outside IDLE is ignored; there is no queueing.
- **Flush:**
  - Any state goes to IDLE next cycle; `Busy` and `Done` drop.
  - `Lo`/`Hi`/`DivByZero` keep their previous completed values.
  - `Flush` and `Start` together in IDLE: `Flush` wins and the request is dropped.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - `Busy`, `Done` and `DivByZero` are 0.
  - `Lo` and `Hi` are 0x00000000.
- `Start` accepted at edge 0. `Busy` is high from edge 0 through edge 33.
- RUN occupies edges 1–32, FIX is edge 33, and `Done` is high for the cycle after edge 33.
- Total latency is 34 cycles from `Start` to `Done`, independent of operand values.
- `Lo`/`Hi` change only at FIX and remain stable through and after `Done`.
- A new `Start` can be accepted the cycle after `Done`, giving a back-to-back period of 35 cycles.
- Reset asserted mid-RUN: immediate return to reset values; there is no partial result.

## Structure
- Package `div_pkg`:
  - `DIV_WIDTH` = 32.
  - `DIV_LATENCY` = 34.
  - State enum `div_state_t` (IDLE, RUN, FIX, DONE).
  - Constant `DIV_ZERO_QUOT` = 0xFFFFFFFF.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
- FSM, counter and sign logic stay in `divider_32bit`.

## Test plan
- Unsigned: `divu` A=100, B=7, `Start` at cycle 0 -> `Done` at cycle 34, `Lo`=14, `Hi`=2, `DivByZero`=0, `Busy` high for exactly 34 cycles.
- Signed signs: `div` A=-7 (0xFFFFFFF9), B=2 -> `Lo`=0xFFFFFFFD (-3), `Hi`=0xFFFFFFFF (-1); A=7, B=-2 -> `Lo`=-3, `Hi`=1.
- Corners:
  - `div` 0x80000000 / 0xFFFFFFFF -> `Lo`=0x80000000, `Hi`=0.
  - `divu` 0xFFFFFFFF / 1 -> `Lo`=0xFFFFFFFF, `Hi`=0.
- Divide by zero: `div` A=-5, B=0 -> after 34 cycles `Lo`=0xFFFFFFFF, `Hi`=0xFFFFFFFB, `DivByZero`=1.
- Control:
  - `Start` pulsed at cycle 10 of an operation is ignored; the result matches the first operands.
  - `Flush` at cycle 20 -> IDLE next cycle, no `Done`, prior `Lo`/`Hi` retained.
  - `Reset_n` low at cycle 15 -> all outputs 0 immediately, a new op after release completes normally.
